// File: rtl/cfu_arbiter.sv
// cfu_arbiter: shares one CFU datapath between two requesters.
//   Port 0 (CPU pipeline) and port 1 (auxiliary master) issue commands over
//   valid/ready. A round-robin grant picks one command at a time. The operands
//   are latched and the CFU gets a one-cycle enable pulse. The result comes back
//   to the winning port over a valid/ready response channel. A timeout aborts
//   a command whose CFU stays stalled too long.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   reqN_valid_i/reqN_ready_o         command handshake (ready is combinational)
//   reqN_funct3_i/funct7_i/src1/src2  command payload
//   rspN_valid_o/rspN_ready_i         response handshake
//   rspN_rslt_o/rspN_err_o            registered result and timeout flag
//   cfu_en_o, cfu_funct*_o, cfu_src*_o  enable pulse and held operands to the CFU
//   cfu_stall_i, cfu_rslt_i           CFU busy and result
module cfu_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [2:0]  req0_funct3_i,
    input  logic [6:0]  req0_funct7_i,
    input  logic [31:0] req0_src1_i,
    input  logic [31:0] req0_src2_i,
    output logic        rsp0_valid_o,
    input  logic        rsp0_ready_i,
    output logic [31:0] rsp0_rslt_o,
    output logic        rsp0_err_o,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [2:0]  req1_funct3_i,
    input  logic [6:0]  req1_funct7_i,
    input  logic [31:0] req1_src1_i,
    input  logic [31:0] req1_src2_i,
    output logic        rsp1_valid_o,
    input  logic        rsp1_ready_i,
    output logic [31:0] rsp1_rslt_o,
    output logic        rsp1_err_o,
    output logic        cfu_en_o,
    output logic [2:0]  cfu_funct3_o,
    output logic [6:0]  cfu_funct7_o,
    output logic [31:0] cfu_src1_o,
    output logic [31:0] cfu_src2_o,
    input  logic        cfu_stall_i,
    input  logic [31:0] cfu_rslt_i
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last_grant;
    logic            owner;
    logic [CW-1:0]   cnt;
    logic            grant;
    logic            req_hs;
    logic            rsp_hs;
    logic            done;
    logic            timeout;

    // Round-robin: a lone requester wins; on contention the port not served last wins.
    always_comb begin
        grant = req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant = ~last_grant;
        end
    end

    assign req0_ready_o = (state == IDLE) && req0_valid_i && !grant;
    assign req1_ready_o = (state == IDLE) && req1_valid_i && grant;
    assign req_hs       = req0_ready_o || req1_ready_o;
    assign rsp_hs       = owner ? (rsp1_valid_o && rsp1_ready_i)
                                : (rsp0_valid_o && rsp0_ready_i);

    // Stall release wins over the timeout when both happen in the same cycle.
    assign done    = ((state == ISSUE) || (state == WAIT)) && !cfu_stall_i;
    assign timeout = (state == WAIT) && cfu_stall_i && (cnt == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (req_hs) state_nxt = ISSUE;
            ISSUE: state_nxt = done ? RESP : WAIT;
            WAIT:  if (done || timeout) state_nxt = RESP;
            RESP:  if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, enable pulse, stall counter and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            cnt          <= '0;
            cfu_en_o     <= 1'b0;
            cfu_funct3_o <= '0;
            cfu_funct7_o <= '0;
            cfu_src1_o   <= '0;
            cfu_src2_o   <= '0;
            rsp0_valid_o <= 1'b0;
            rsp0_rslt_o  <= '0;
            rsp0_err_o   <= 1'b0;
            rsp1_valid_o <= 1'b0;
            rsp1_rslt_o  <= '0;
            rsp1_err_o   <= 1'b0;
        end else begin
            cfu_en_o <= (state == IDLE) && req_hs;

            if ((state == IDLE) && req_hs) begin
                cfu_funct3_o <= grant ? req1_funct3_i : req0_funct3_i;
                cfu_funct7_o <= grant ? req1_funct7_i : req0_funct7_i;
                cfu_src1_o   <= grant ? req1_src1_i   : req0_src1_i;
                cfu_src2_o   <= grant ? req1_src2_i   : req0_src2_i;
                owner        <= grant;
                last_grant   <= grant;
                cnt          <= '0;
            end

            // The ISSUE cycle counts as the first stalled cycle.
            if ((state == ISSUE) && cfu_stall_i) begin
                cnt <= CW'(1);
            end else if ((state == WAIT) && cfu_stall_i && !timeout) begin
                cnt <= cnt + CW'(1);
            end

            if (done || timeout) begin
                if (owner) begin
                    rsp1_valid_o <= 1'b1;
                    rsp1_rslt_o  <= done ? cfu_rslt_i : 32'h0;
                    rsp1_err_o   <= timeout;
                end else begin
                    rsp0_valid_o <= 1'b1;
                    rsp0_rslt_o  <= done ? cfu_rslt_i : 32'h0;
                    rsp0_err_o   <= timeout;
                end
            end

            if ((state == RESP) && rsp_hs) begin
                rsp0_valid_o <= 1'b0;
                rsp1_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cfu_arbiter.sv
// Directed bench for cfu_arbiter with TIMEOUT=8 and a simple OR-based CFU model.
module tb_cfu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
    logic [2:0]  req0_funct3;
    logic [6:0]  req0_funct7;
    logic [31:0] req0_src1, req0_src2, rsp0_rslt;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
    logic [2:0]  req1_funct3;
    logic [6:0]  req1_funct7;
    logic [31:0] req1_src1, req1_src2, rsp1_rslt;
    logic        cfu_en, cfu_stall;
    logic [2:0]  cfu_funct3;
    logic [6:0]  cfu_funct7;
    logic [31:0] cfu_src1, cfu_src2, cfu_rslt, rslt_force;
    logic        use_model;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] es1, es2;
    int          gp;

    // CFU stand-in: combinational OR of the operands, or a forced value.
    assign cfu_rslt = use_model ? (cfu_src1 | cfu_src2) : rslt_force;

    always #5 clk = ~clk;

    cfu_arbiter #(.TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_funct3_i(req0_funct3), .req0_funct7_i(req0_funct7),
        .req0_src1_i(req0_src1), .req0_src2_i(req0_src2),
        .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
        .rsp0_rslt_o(rsp0_rslt), .rsp0_err_o(rsp0_err),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_funct3_i(req1_funct3), .req1_funct7_i(req1_funct7),
        .req1_src1_i(req1_src1), .req1_src2_i(req1_src2),
        .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
        .rsp1_rslt_o(rsp1_rslt), .rsp1_err_o(rsp1_err),
        .cfu_en_o(cfu_en), .cfu_funct3_o(cfu_funct3), .cfu_funct7_o(cfu_funct7),
        .cfu_src1_o(cfu_src1), .cfu_src2_o(cfu_src2),
        .cfu_stall_i(cfu_stall), .cfu_rslt_i(cfu_rslt)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_funct3 = 0; req0_funct7 = 0; req0_src1 = 0; req0_src2 = 0;
        req1_valid = 0; req1_funct3 = 0; req1_funct7 = 0; req1_src1 = 0; req1_src2 = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        cfu_stall = 0; rslt_force = 0; use_model = 1;
        #2;
        chk1("rst_en", cfu_en, 1'b0);
        chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk1("rst_err0", rsp0_err, 1'b0);
        chk32("rst_src1", cfu_src1, 32'h0);
        chk32("rst_rslt0", rsp0_rslt, 32'h0);
        cyc(); cyc();
        rst = 1'b0;

        // Single request on port 0, zero-latency CFU.
        cyc();
        req0_valid = 1; req0_funct3 = 3'd0; req0_src1 = 32'h0000_00F0; req0_src2 = 32'h0000_000F;
        #1;
        chk1("t1_ready0", req0_ready, 1'b1);
        chk1("t1_ready1", req1_ready, 1'b0);
        cyc(); req0_valid = 0; #1;
        chk1("t1_en_issue", cfu_en, 1'b1);
        chk32("t1_src1", cfu_src1, 32'h0000_00F0);
        chk32("t1_src2", cfu_src2, 32'h0000_000F);
        chk1("t1_rsp0_early", rsp0_valid, 1'b0);
        chk1("t1_ready0_busy", req0_ready, 1'b0);
        cyc(); #1;
        chk1("t1_en_off", cfu_en, 1'b0);
        chk1("t1_rsp0_valid", rsp0_valid, 1'b1);
        chk32("t1_rslt0", rsp0_rslt, 32'h0000_00FF);
        chk1("t1_err0", rsp0_err, 1'b0);
        chk1("t1_rsp1_quiet", rsp1_valid, 1'b0);
        cyc(); #1;
        chk1("t1_rsp0_clear", rsp0_valid, 1'b0);

        // Multi-cycle CFU on port 1: stall high for 5 cycles from issue.
        cyc();
        use_model = 0; rslt_force = 32'hDEAD_BEEF; cfu_stall = 1;
        req1_valid = 1; req1_funct3 = 3'd5; req1_funct7 = 7'h2A;
        req1_src1 = 32'h1111_1111; req1_src2 = 32'h2222_2222;
        #1;
        chk1("t3_ready1", req1_ready, 1'b1);
        cyc(); req1_valid = 0; #1;
        chk1("t3_en_issue", cfu_en, 1'b1);
        chk32("t3_funct7", 32'(cfu_funct7), 32'h2A);
        chk32("t3_funct3", 32'(cfu_funct3), 32'h5);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk1("t3_en_stall", cfu_en, 1'b0);
            chk32("t3_src1_hold", cfu_src1, 32'h1111_1111);
            chk32("t3_src2_hold", cfu_src2, 32'h2222_2222);
            chk1("t3_rsp1_early", rsp1_valid, 1'b0);
        end
        cyc(); cfu_stall = 0; #1;
        chk1("t3_rsp1_wait", rsp1_valid, 1'b0);
        cyc(); #1;
        chk1("t3_rsp1_valid", rsp1_valid, 1'b1);
        chk32("t3_rslt1", rsp1_rslt, 32'hDEAD_BEEF);
        chk1("t3_err1", rsp1_err, 1'b0);
        chk1("t3_rsp0_quiet", rsp0_valid, 1'b0);
        cyc(); #1;
        chk1("t3_rsp1_clear", rsp1_valid, 1'b0);

        // Contention: both ports valid throughout, grants alternate 0,1,0,1.
        cyc();
        use_model = 1;
        req0_src1 = 32'h0000_1000; req0_src2 = 32'h0000_0010; req0_valid = 1;
        req1_src1 = 32'h0002_0000; req1_src2 = 32'h0000_0200; req1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            gp = k % 2;
            #1;
            chk1("t2_ready0", req0_ready, gp == 0);
            chk1("t2_ready1", req1_ready, gp == 1);
            es1 = (gp == 0) ? req0_src1 : req1_src1;
            es2 = (gp == 0) ? req0_src2 : req1_src2;
            cyc();
            if (k == 3) begin
                req0_valid = 0; req1_valid = 0;
            end else if (gp == 0) begin
                req0_src1 = req0_src1 + 32'h1;
            end else begin
                req1_src1 = req1_src1 + 32'h1;
            end
            #1;
            chk1("t2_en", cfu_en, 1'b1);
            chk32("t2_src1", cfu_src1, es1);
            chk1("t2_no_ready0", req0_ready, 1'b0);
            chk1("t2_no_ready1", req1_ready, 1'b0);
            cyc(); #1;
            chk1("t2_en_off", cfu_en, 1'b0);
            chk1("t2_rsp0_valid", rsp0_valid, gp == 0);
            chk1("t2_rsp1_valid", rsp1_valid, gp == 1);
            chk32("t2_rslt", (gp == 0) ? rsp0_rslt : rsp1_rslt, es1 | es2);
            cyc();
        end

        // Timeout on port 0: stall stuck high for 8 cycles.
        use_model = 0; rslt_force = 32'h1234_5678; cfu_stall = 1;
        req0_src1 = 32'h0000_000A; req0_src2 = 32'h0; req0_valid = 1;
        #1;
        chk1("t4_ready0", req0_ready, 1'b1);
        cyc(); req0_valid = 0; #1;
        chk1("t4_en_issue", cfu_en, 1'b1);
        for (int i = 0; i < 7; i++) begin
            cyc(); #1;
            chk1("t4_rsp0_early", rsp0_valid, 1'b0);
            chk1("t4_en_stall", cfu_en, 1'b0);
        end
        cyc(); #1;
        chk1("t4_rsp0_valid", rsp0_valid, 1'b1);
        chk1("t4_err0", rsp0_err, 1'b1);
        chk32("t4_rslt0", rsp0_rslt, 32'h0);
        cyc();
        cfu_stall = 0; use_model = 1;
        req1_src1 = 32'h0000_0300; req1_src2 = 32'h0000_000C; req1_valid = 1;
        #1;
        chk1("t4_rsp0_clear", rsp0_valid, 1'b0);
        chk1("t4_ready1", req1_ready, 1'b1);
        cyc(); req1_valid = 0; #1;
        chk1("t4_en_next", cfu_en, 1'b1);
        cyc(); #1;
        chk1("t4_rsp1_valid", rsp1_valid, 1'b1);
        chk32("t4_rslt1", rsp1_rslt, 32'h0000_030C);
        chk1("t4_err1", rsp1_err, 1'b0);
        cyc();

        // Response backpressure on port 1 while port 0 waits.
        rsp1_ready = 0;
        req1_src1 = 32'h0000_5000; req1_src2 = 32'h0000_00A5; req1_valid = 1;
        #1;
        chk1("t5_ready1", req1_ready, 1'b1);
        cyc();
        req1_valid = 0;
        req0_src1 = 32'h0000_0077; req0_src2 = 32'h0000_8800; req0_valid = 1;
        #1;
        chk1("t5_ready0_issue", req0_ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            chk1("t5_rsp1_hold", rsp1_valid, 1'b1);
            chk32("t5_rslt1_hold", rsp1_rslt, 32'h0000_50A5);
            chk1("t5_ready0_block", req0_ready, 1'b0);
            chk1("t5_rsp0_quiet", rsp0_valid, 1'b0);
        end
        cyc(); rsp1_ready = 1; #1;
        chk1("t5_rsp1_still", rsp1_valid, 1'b1);
        chk1("t5_ready0_hs", req0_ready, 1'b0);
        cyc(); #1;
        chk1("t5_rsp1_clear", rsp1_valid, 1'b0);
        chk1("t5_ready0_grant", req0_ready, 1'b1);
        cyc(); req0_valid = 0; #1;
        chk1("t5_en", cfu_en, 1'b1);
        chk32("t5_src1", cfu_src1, 32'h0000_0077);
        cyc(); #1;
        chk1("t5_rsp0_valid", rsp0_valid, 1'b1);
        chk32("t5_rslt0", rsp0_rslt, 32'h0000_8877);
        cyc();

        // Asynchronous reset while the CFU stalls.
        cfu_stall = 1;
        req0_src1 = 32'h0000_CAFE; req0_src2 = 32'h0; req0_valid = 1;
        #1;
        chk1("t6_ready0", req0_ready, 1'b1);
        cyc(); req0_valid = 0; #1;
        chk1("t6_en_issue", cfu_en, 1'b1);
        cyc(); #1;
        chk32("t6_src1_wait", cfu_src1, 32'h0000_CAFE);
        #1; rst = 1; #1;
        chk1("t6_en_rst", cfu_en, 1'b0);
        chk32("t6_src1_rst", cfu_src1, 32'h0);
        chk1("t6_rsp0_rst", rsp0_valid, 1'b0);
        chk1("t6_rsp1_rst", rsp1_valid, 1'b0);
        chk1("t6_ready0_rst", req0_ready, 1'b0);
        #2; rst = 0; cfu_stall = 0;
        req0_src1 = 32'h0000_0101; req0_src2 = 32'h0000_1010; req0_valid = 1;
        req1_src1 = 32'h0000_0202; req1_src2 = 32'h0000_2020; req1_valid = 1;
        #1;
        chk1("t6_ready0_first", req0_ready, 1'b1);
        chk1("t6_ready1_first", req1_ready, 1'b0);
        cyc(); req0_valid = 0; req1_valid = 0; #1;
        chk1("t6_en_after", cfu_en, 1'b1);
        chk32("t6_src1_after", cfu_src1, 32'h0000_0101);
        cyc(); #1;
        chk1("t6_rsp0_valid", rsp0_valid, 1'b1);
        chk32("t6_rslt0", rsp0_rslt, 32'h0000_1111);
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfu_arbiter.md
Name: cfu_arbiter

Overview:
- Shares the single CFU datapath between two requesters (port 0: CPU pipeline, port 1: auxiliary master such as a DMA/accelerator sequencer).
- Accepts one command at a time through valid/ready handshakes and arbitrates round-robin between the ports.
- Latches the operands, issues a one-cycle enable pulse to the CFU and holds the operands stable while the CFU stalls.
- Captures the result and returns it to the winning requester through a valid/ready response channel, with a timeout guard against a hung CFU.

Parameters:
TIMEOUT, 256, maximum number of cycles a command may spend stalled before it is aborted with an error (must be >= 2).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
req0_valid_i  in  1  port 0 command valid
req0_ready_o  out  1  port 0 command accepted this cycle
req0_funct3_i  in  3  port 0 funct3
req0_funct7_i  in  7  port 0 funct7
req0_src1_i  in  32  port 0 operand 1
req0_src2_i  in  32  port 0 operand 2
rsp0_valid_o  out  1  port 0 response valid
rsp0_ready_i  in  1  port 0 response accepted
rsp0_rslt_o  out  32  port 0 result
rsp0_err_o  out  1  port 0 timeout error flag
req1_* / rsp1_*  same set as port 0  port 1
cfu_en_o  out  1  CFU enable pulse
cfu_funct3_o  out  3  to CFU
cfu_funct7_o  out  7  to CFU
cfu_src1_o  out  32  to CFU
cfu_src2_o  out  32  to CFU
cfu_stall_i  in  1  CFU busy
cfu_rslt_i  in  32  CFU result

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous and active-high on rst_i; all state resets immediately.
- Reset values:
  - state = IDLE.
  - Outputs cfu_en_o, all ready_o, valid_o and err_o = 0.
  - cfu_* operands = 0; rsp*_rslt_o = 0.
  - last_grant = 1, so port 0 wins the first contention.
  - Timeout counter = 0.
  - Counter width is $clog2(TIMEOUT+1).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = the sole valid port; if both ports are valid, grant = the port != last_grant.
  - reqN_ready_o = (state==IDLE) && reqN_valid_i && grant==N. This is combinational, and at most one ready is high per cycle.
  - On handshake: latch funct3/funct7/src1/src2 into the cfu_* registers, record owner=N, set last_grant=N, clear the counter, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - cfu_en_o = 1 in this cycle only.
  - If cfu_stall_i==0: capture cfu_rslt_i into rspN_rslt_o, set err=0, go to RESP. Minimum latency is 2 cycles from handshake to rsp valid.
  - Else go to WAIT, with counter = 1.
- WAIT:
  - cfu_en_o = 0; the cfu_* operands stay unchanged.
  - If cfu_stall_i==0: capture the result, set err=0, go to RESP.
  - Else if counter == TIMEOUT-1: set rslt=0, err=1, go to RESP.
  - Else increment the counter.
  - The stall check has priority over the timeout in the same cycle.
- RESP:
  - rsp{owner}_valid_o = 1, and rslt/err are held stable until rsp{owner}_ready_i.
  - On handshake: clear valid, go to IDLE. The next request can be accepted no earlier than the following cycle.
  - The other port's rsp_valid_o stays 0 throughout.
- Operand stability: the cfu_* operands never change outside the IDLE handshake cycle. Only one command is in flight; no pipelining.
- Requests arriving while state != IDLE see ready=0 and must hold; no request is dropped.
- A requester deasserting valid before ready (a protocol violation) is not required to be handled.
- Reset mid-operation:
  - Returns to IDLE, drops the in-flight command and clears responses.
  - The CFU itself has no reset. After reset, the first issue waits in ISSUE/WAIT until stall_i drops, with the timeout applying as normal.
- rsp*_rslt_o and rsp*_err_o are don't-care when their valid is low, but are registered (no combinational path from cfu_rslt_i).

Test Plan:
- Single request, combinational CFU: port 0 sends funct3=0, src1=0x0000_00F0, src2=0x0000_000F, stall tied 0 -> req0_ready pulses once, cfu_en_o high for exactly 1 cycle, rsp0_valid 2 cycles after handshake with rslt=0x0000_00FF, err=0.
- Contention and round-robin: both ports hold valid continuously for 4 commands -> grants go 0,1,0,1. Each rsp appears only on its own port; cfu_en_o never overlaps an outstanding command.
- Multi-cycle CFU: stall held high 5 cycles after issue, rslt=0xDEAD_BEEF -> cfu_src1/2 stable throughout, no second en pulse; rsp valid the cycle after stall drops with 0xDEAD_BEEF.
- Timeout: TIMEOUT=8, stall stuck high -> rsp valid after 8 stalled cycles with err=1, rslt=0. Then stall drops and the next command completes normally.
- Response backpressure: rsp1_ready low for 10 cycles -> rsp1_valid and data held constant; req0_ready stays 0 until the rsp1 handshake, and port 0 is granted the following cycle.
- Async reset in WAIT: assert rst_i mid-cycle -> cfu_en_o, ready/valid go 0 immediately without a clock edge; after release, port 0 wins the first contention.
